// File: rtl/mul_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared pipelined multiplier; a tag pipeline
// carries requester ids alongside the product. Define MUL_ARB_STATS_EN for per-requester issue counters.
module mul_issue_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  localparam int ID_W   = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic                     issue_stall,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_s,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     busy
`ifdef MUL_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_REQ*16-1:0]    issue_cnt
`endif
);

  // Handshake: requester i transfers operands in any cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot or zero and never depends on the requester accepting anything back.
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic            hs;

  // Two passes: lowest valid index below ptr, then overridden by lowest valid index at/above ptr.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i < int'(ptr))) begin
        gnt_id  = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(ptr))) begin
        gnt_id  = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

  assign hs = gnt_any & ~issue_stall;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (hs) begin
      ptr   <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      mul_a <= req_a[gnt_id*WIDTH +: WIDTH];
      mul_b <= req_b[gnt_id*WIDTH +: WIDTH];
    end
  end

  // Stage LATENCY-1 lines up with the cycle in which mul_s holds this issue's product.
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_v[LATENCY-1];
      rsp_id    <= tag_id[LATENCY-1];
      if (tag_v[LATENCY-1]) rsp_data <= mul_s;
    end
  end

  assign busy = (|tag_v) | rsp_valid;

`ifdef MUL_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) cnt[i] <= '0;
        else if (hs && (gnt_id == ID_W'(i)) && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) issue_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Scoreboard bench for mul_issue_arbiter with a behavioural LATENCY=4 multiplier;
// driver pushes hand-computed {cycle, id, product}, monitor pops on rsp_valid.
module tb_mul_issue_arbiter;
  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 4;
  localparam int ID_W    = 1;
  localparam int EW      = 32 + ID_W + 2*WIDTH;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic                     issue_stall = 1'b0;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [2*WIDTH-1:0]       mul_s;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     busy;
`ifdef MUL_ARB_STATS_EN
  logic                     stats_clr = 1'b0;
  logic [NUM_REQ*16-1:0]    issue_cnt;
`endif

  mul_issue_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .issue_stall(issue_stall),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef MUL_ARB_STATS_EN
    , .stats_clr(stats_clr), .issue_cnt(issue_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: operands visible in cycle t+1 give a product in cycle t+LATENCY.
  logic [2*WIDTH-1:0] mpipe [LATENCY-1];
  always @(posedge clk) begin
    mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int k = 1; k < LATENCY - 1; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_s = mpipe[LATENCY-2];

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_rsp at cycle %0d: actual id=%0d data=%0h expected none", cyc, rsp_id, rsp_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("rsp_cycle", 128'(cyc), 128'(exp_e[EW-1 -: 32]));
        check("rsp_id", 128'(rsp_id), 128'(exp_e[2*WIDTH]));
        check("rsp_data", 128'(rsp_data), 128'(exp_e[2*WIDTH-1:0]));
      end
    end
  end

  // driver tasks: called just after a rising edge, leave just after the next one
  task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic stall,
                      input logic [1:0] exp_rdy, input logic [63:0] exp_p, input bit push);
    req_valid   = v;
    req_a       = {a1, a0};
    req_b       = {b1, b0};
    issue_stall = stall;
    @(negedge clk);
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    if (push && (exp_rdy != 2'b00)) exp_q.push_back({32'(cyc + LATENCY + 1), exp_rdy[1], exp_p});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 64'd0, 1'b0);
  endtask

  initial begin
    // 1. reset with all requesters valid
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mul_a", 128'(mul_a), 128'd0);
    check("rst_mul_b", 128'(mul_b), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_id", 128'(rsp_id), 128'd0);
    check("rst_rsp_data", 128'(rsp_data), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 2'b00;
    idle(2);

    // 2. single issue, 3*5, response 5 cycles later
    step(2'b01, 32'd3, 32'd5, 0, 0, 1'b0, 2'b01, 64'd15, 1'b1);
    check("busy_in_flight", 128'(busy), 128'd1);
    idle(7);
    check("busy_drained", 128'(busy), 128'd0);

    // 3. bring ptr to 0 via req1, then contention alternates 0,1,0,1
    step(2'b10, 0, 0, 32'd2, 32'd2, 1'b0, 2'b10, 64'd4, 1'b1);
    step(2'b11, 32'd6, 32'd7, 32'd8, 32'd9, 1'b0, 2'b01, 64'd42, 1'b1);
    step(2'b11, 32'd6, 32'd7, 32'd8, 32'd9, 1'b0, 2'b10, 64'd72, 1'b1);
    step(2'b11, 32'd10, 32'd11, 32'd12, 32'd13, 1'b0, 2'b01, 64'd110, 1'b1);
    step(2'b11, 32'd10, 32'd11, 32'd12, 32'd13, 1'b0, 2'b10, 64'd156, 1'b1);
    idle(7);

    // 4. max operands followed back-to-back by 7*9
    step(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 2'b01, 64'hFFFF_FFFE_0000_0001, 1'b1);
    step(2'b10, 0, 0, 32'd7, 32'd9, 1'b0, 2'b10, 64'd63, 1'b1);
    idle(7);

    // 5. stall with req1 waiting while an earlier op drains
    step(2'b01, 32'd4, 32'd4, 0, 0, 1'b0, 2'b01, 64'd16, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b10, 0, 0, 32'd5, 32'd6, 1'b1, 2'b00, 64'd0, 1'b0);
    step(2'b10, 0, 0, 32'd5, 32'd6, 1'b0, 2'b10, 64'd30, 1'b1);
    idle(7);

    // 6. reset two cycles after an issue discards it
    step(2'b01, 32'd9, 32'd9, 0, 0, 1'b0, 2'b01, 64'd81, 1'b0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_mul_a", 128'(mul_a), 128'd0);
`ifdef MUL_ARB_STATS_EN
    check("midrst_issue_cnt", 128'(issue_cnt), 128'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(7);
    // pointer is back at 0, so req0 wins with both valid
    step(2'b11, 32'd11, 32'd13, 32'd1, 32'd1, 1'b0, 2'b01, 64'd143, 1'b1);
    idle(7);

    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
